// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one spi_master among NREQ requesters.
// Registers one packed transaction per grant and reports done/timeout per requester.
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ*(DWIDTH+AWIDTH+5)-1:0]   req_data,
  input  logic [NREQ*2-1:0]                   req_cfg,
  output logic [NREQ-1:0]                     req_ready,
  output logic [NREQ-1:0]                     req_done,
  output logic [NREQ-1:0]                     req_err,
  output logic                                master_en,
  output logic [DWIDTH+AWIDTH+4:0]            drv_data,
  output logic [1:0]                          drv_cfg,
  input  logic                                drv_read,
  output logic                                busy,
  output logic [$clog2(NREQ)-1:0]             grant_id
);

  localparam int TW = DWIDTH + AWIDTH + 5;
  localparam int GW = $clog2(NREQ);
  localparam int CW = ($clog2(TIMEOUT) + 1 > 16) ? $clog2(TIMEOUT) + 1 : 16;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t         state, state_nx;
  logic [GW-1:0]  rr_ptr;
  logic [GW-1:0]  rr_next;
  logic [GW-1:0]  pick;
  logic           pick_ok;
  logic [CW-1:0]  tmo_cnt;
  logic           tmo_hit;
  logic           accept;
  logic           finish;

  // Scan from the highest offset down so the nearest valid bit at/after rr_ptr wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_valid[(int'(rr_ptr) + off) % NREQ]) begin
        pick    = GW'((int'(rr_ptr) + off) % NREQ);
        pick_ok = 1'b1;
      end
    end
  end

  assign rr_next = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx  = state;
    master_en = 1'b0;
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so a held req_valid cannot show a ready pulse during reset.
        if (pick_ok && rst_n) begin
          req_ready[pick] = 1'b1;
          accept          = 1'b1;
          state_nx        = ISSUE;
        end
      end
      ISSUE: begin
        if (tmo_hit) begin
          req_err[grant_id] = 1'b1;
          finish            = 1'b1;
          state_nx          = IDLE;
        end else begin
          master_en = 1'b1;
          if (!drv_read) state_nx = BUSY;
        end
      end
      BUSY: begin
        // Timeout has priority over a completion seen in the same cycle.
        if (tmo_hit) begin
          req_err[grant_id] = 1'b1;
          finish            = 1'b1;
          state_nx          = IDLE;
        end else if (drv_read) begin
          req_done[grant_id] = 1'b1;
          finish             = 1'b1;
          state_nx           = IDLE;
        end else begin
          master_en = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      drv_data <= '0;
      drv_cfg  <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        grant_id <= pick;
        drv_data <= req_data[int'(pick)*TW +: TW];
        drv_cfg  <= req_cfg[int'(pick)*2 +: 2];
        tmo_cnt  <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (finish) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a small behavioural spi_master model.
`timescale 1ns/1ps
module tb_spi_txn_arbiter;

  localparam int NREQ    = 4;
  localparam int DWIDTH  = 8;
  localparam int AWIDTH  = 8;
  localparam int TIMEOUT = 64;
  localparam int TW      = DWIDTH + AWIDTH + 5;
  localparam logic [TW-1:0] W1 = {2'd2, 8'hA5, 8'h3C, 2'd0, 1'b1};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*TW-1:0]   req_data;
  logic [NREQ*2-1:0]    req_cfg;
  logic [NREQ-1:0]      req_ready, req_done, req_err;
  logic                 master_en;
  logic [TW-1:0]        drv_data;
  logic [1:0]           drv_cfg;
  logic                 drv_read;
  logic                 busy;
  logic [1:0]           grant_id;

  spi_txn_arbiter #(
    .NREQ(NREQ), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_cfg(req_cfg), .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .master_en(master_en), .drv_data(drv_data), .drv_cfg(drv_cfg),
    .drv_read(drv_read), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // spi_master stand-in: leaves RESET when enabled, returns after xfer_len+1 cycles unless hung.
  logic m_busy;
  int   m_cnt;
  int   xfer_len = 2;
  logic hang = 1'b0;
  logic [3:0] ss_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (master_en) begin
        m_busy <= 1'b1;
        m_cnt  <= xfer_len;
      end
    end else if (!hang) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end
  assign drv_read = !m_busy;
  assign ss_n     = m_busy ? ~(4'b0001 << drv_data[TW-1 -: 2]) : 4'b1111;

  int   ready_cnt[NREQ], done_cnt[NREQ], err_cnt[NREQ];
  int   tot_ready, tot_done, tot_err;
  int   grant_q[$];
  int   last_ready_cyc, last_err_cyc;
  logic en_at_err;
  logic [3:0] last_ss_n;
  int   pulse_viol = 0;
  int   cfg_glitch = 0;
  logic prev_en = 1'b0;
  logic [1:0] prev_cfg = 2'b00;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(req_ready) > 1 || $countones(req_done) > 1 ||
          $countones(req_err) > 1 || (req_done != 0 && req_err != 0))
        pulse_viol++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          ready_cnt[i]++; tot_ready++; grant_q.push_back(i); last_ready_cyc = cyc;
        end
        if (req_done[i]) begin
          done_cnt[i]++; tot_done++;
        end
        if (req_err[i]) begin
          err_cnt[i]++; tot_err++; last_err_cyc = cyc; en_at_err = master_en;
        end
      end
      if (m_busy) last_ss_n = ss_n;
      if (prev_en && master_en && drv_cfg != prev_cfg) cfg_glitch++;
      prev_en  = master_en;
      prev_cfg = drv_cfg;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < NREQ; i++) begin
      ready_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
    end
    tot_ready = 0; tot_done = 0; tot_err = 0;
    grant_q.delete();
    last_ss_n = 4'b1111;
    en_at_err = 1'b1;
  endtask

  function automatic int count_of(input int kind);
    return (kind == 0) ? tot_ready : (kind == 1) ? tot_done : tot_err;
  endfunction

  // kind: 0 = ready pulses, 1 = done pulses, 2 = err pulses
  task automatic wait_count(input int kind, input int target, input int max_cyc, input string tag);
    int n = 0;
    while (count_of(kind) < target && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (count_of(kind) < target) begin
      errors++;
      $display("[TB] FAIL %s: wait expired, count=%0d required=%0d", tag, count_of(kind), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_data = '0; req_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, req_done, req_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got %b required 0", {req_ready, req_done, req_err});
    end
    checks++;
    if ({master_en, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_en_busy: got %b required 00", {master_en, busy});
    end
    checks++;
    if ({drv_data, drv_cfg, grant_id} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: data=%h cfg=%b gid=%0d required 0", drv_data, drv_cfg, grant_id);
    end
    req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    clear_stats();
    req_data[0 +: TW] = W1;
    req_cfg[1:0]      = 2'b01;
    req_valid         = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid         = '0;
    req_data[0 +: TW] = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_ready_width: got %b required 0000", req_ready);
    end
    checks++;
    if ({master_en, busy, grant_id, drv_cfg} !== {1'b1, 1'b1, 2'd0, 2'b01}) begin
      errors++;
      $display("[TB] FAIL single_issue: en=%b busy=%b gid=%0d cfg=%b required 1 1 0 01",
               master_en, busy, grant_id, drv_cfg);
    end
    wait_count(1, 1, 40, "single_done_wait");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (drv_data !== W1) begin
      errors++;
      $display("[TB] FAIL single_data_hold: got %h required %h", drv_data, W1);
    end
    checks++;
    if (last_ss_n !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL single_ss_n: got %b required 1011", last_ss_n);
    end
    checks++;
    if (done_cnt[0] !== 1 || tot_done !== 1 || tot_ready !== 1 || tot_err !== 0) begin
      errors++;
      $display("[TB] FAIL single_counts: done0=%0d done=%0d ready=%0d err=%0d required 1 1 1 0",
               done_cnt[0], tot_done, tot_ready, tot_err);
    end
    checks++;
    if ({master_en, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_idle: got %b required 00", {master_en, busy});
    end
  endtask

  task automatic test_fairness();
    int exp_q[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int got;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    for (int i = 0; i < NREQ; i++) req_data[i*TW +: TW] = TW'(32'h1000 + i);
    req_cfg   = '0;
    req_valid = 4'b1111;
    wait_count(1, 8, 200, "fair_done_wait");
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (grant_q.size() !== 8) begin
      errors++;
      $display("[TB] FAIL fair_grant_count: got %0d required 8", grant_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < grant_q.size()) ? grant_q[i] : -1;
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL fair_order[%0d]: got %0d required %0d", i, got, exp_q[i]);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (done_cnt[i] !== 2) begin
        errors++;
        $display("[TB] FAIL fair_done[%0d]: got %0d required 2", i, done_cnt[i]);
      end
    end
  endtask

  task automatic test_skip_wrap();
    int exp_q[3] = '{2, 0, 1};
    int got;
    clear_stats();
    req_valid = 4'b0100;
    wait_count(0, 1, 10, "wrap_first_grant");
    req_valid = 4'b0011;
    wait_count(0, 3, 60, "wrap_grants");
    req_valid = '0;
    wait_count(1, 3, 60, "wrap_done_wait");
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      got = (i < grant_q.size()) ? grant_q[i] : -1;
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL wrap_order[%0d]: got %0d required %0d", i, got, exp_q[i]);
      end
    end
    checks++;
    if (grant_id !== 2'd1 || tot_ready !== 3) begin
      errors++;
      $display("[TB] FAIL wrap_final: gid=%0d ready=%0d required 1 3", grant_id, tot_ready);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_stats();
    hang      = 1'b1;
    req_valid = 4'b0010;
    wait_count(0, 1, 10, "tmo_grant");
    req_valid = '0;
    wait_count(2, 1, 100, "tmo_err_wait");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (last_err_cyc - last_ready_cyc !== TIMEOUT) begin
      errors++;
      $display("[TB] FAIL tmo_latency: got %0d required %0d", last_err_cyc - last_ready_cyc, TIMEOUT);
    end
    checks++;
    if (err_cnt[1] !== 1 || tot_done !== 0) begin
      errors++;
      $display("[TB] FAIL tmo_counts: err1=%0d done=%0d required 1 0", err_cnt[1], tot_done);
    end
    checks++;
    if (en_at_err !== 1'b0 || {master_en, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL tmo_en: en_at_err=%b en=%b busy=%b required 0 0 0", en_at_err, master_en, busy);
    end
    hang = 1'b0;
    while (!drv_read && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (drv_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_master_park: drv_read=%b required 1", drv_read);
    end
    req_valid = 4'b0001;
    wait_count(0, 2, 10, "tmo_next_grant");
    req_valid = '0;
    wait_count(1, 1, 40, "tmo_next_done");
    checks++;
    if (done_cnt[0] !== 1 || tot_err !== 1) begin
      errors++;
      $display("[TB] FAIL tmo_recover: done0=%0d err=%0d required 1 1", done_cnt[0], tot_err);
    end
  endtask

  task automatic test_reset_mid_busy();
    clear_stats();
    xfer_len  = 10;
    req_valid = 4'b0100;
    wait_count(0, 1, 10, "rst_grant");
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({master_en, busy, drv_read} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL rst_in_busy: en/busy/read=%b required 110", {master_en, busy, drv_read});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, req_done, req_err, master_en, busy, drv_data, drv_cfg, grant_id} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: en=%b busy=%b data=%h cfg=%b gid=%0d required all 0",
               master_en, busy, drv_data, drv_cfg, grant_id);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    xfer_len = 2;
    clear_stats();
    req_valid = 4'b1000;
    wait_count(0, 1, 10, "rst_new_grant");
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd3) begin
      errors++;
      $display("[TB] FAIL rst_new_gid: got %0d required 3", grant_id);
    end
    wait_count(1, 1, 40, "rst_new_done");
    checks++;
    if (done_cnt[3] !== 1 || tot_err !== 0) begin
      errors++;
      $display("[TB] FAIL rst_new_counts: done3=%0d err=%0d required 1 0", done_cnt[3], tot_err);
    end
  endtask

  task automatic test_cfg();
    clear_stats();
    req_cfg   = 8'b0000_1100;
    req_valid = 4'b0011;
    wait_count(0, 1, 10, "cfg_grant0");
    checks++;
    if (grant_id !== 2'd0 || drv_cfg !== 2'b00) begin
      errors++;
      $display("[TB] FAIL cfg_req0: gid=%0d cfg=%b required 0 00", grant_id, drv_cfg);
    end
    wait_count(0, 2, 40, "cfg_grant1");
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd1 || drv_cfg !== 2'b11) begin
      errors++;
      $display("[TB] FAIL cfg_req1: gid=%0d cfg=%b required 1 11", grant_id, drv_cfg);
    end
    wait_count(1, 2, 40, "cfg_done_wait");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (drv_cfg !== 2'b11) begin
      errors++;
      $display("[TB] FAIL cfg_hold: got %b required 11", drv_cfg);
    end
    checks++;
    if (cfg_glitch !== 0 || pulse_viol !== 0) begin
      errors++;
      $display("[TB] FAIL cfg_glitch_pulses: glitch=%0d pulse_viol=%0d required 0 0", cfg_glitch, pulse_viol);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single();
    test_fairness();
    test_skip_wrap();
    test_timeout();
    test_reset_mid_busy();
    test_cfg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
